// File: rtl/elevator_n.sv
// N-floor elevator controller: sticky hall/car calls, sweep-direction FSM, door timer.
// Optional macro ELEVATOR_DOOR_CLOSE_EN lets the door-close button cut the open time short.
module elevator_n #(
  parameter  int NUM_FLOORS  = 4,
  parameter  int DOOR_CYCLES = 8,
  localparam int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] u_req,
  input  logic [NUM_FLOORS-1:0] d_req,
  input  logic [NUM_FLOORS-1:0] f_req,
  input  logic                  dc,
  input  logic [FW-1:0]         fs,
  input  logic                  fs_valid,
  output logic                  door,
  output logic [1:0]            dir,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, OPEN} state_t;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DN    = 2'b10;
  localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES);

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i > int'(f)) r |= v[i];
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i < int'(f)) r |= v[i];
    return r;
  endfunction

  function automatic logic bit_at(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (i == int'(f)) r = v[i];
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [NUM_FLOORS-1:0] r;
    for (int i = 0; i < NUM_FLOORS; i++) r[i] = (i == int'(f));
    return r;
  endfunction

  state_t                state;
  logic                  run;
  logic                  sweep_up;
  logic [7:0]            timer;
  logic [FW-1:0]         cur;
  logic [NUM_FLOORS-1:0] up_q, dn_q, car_q;

  logic [NUM_FLOORS-1:0] calls, u_eff, d_eff;
  logic [NUM_FLOORS-1:0] ent_mask, cur_mask, clr_up, clr_dn, clr_car, srv_up, srv_dn, srv_car;
  logic [NUM_FLOORS-1:0] up_n, dn_n, car_n;
  logic [FW-1:0]         open_floor;
  logic                  fs_ok, enter_open, open_up, go_up, go_dn, ent_beyond;
  logic                  more_ahead, more_behind, new_hit, expire;

`ifndef ELEVATOR_DOOR_CLOSE_EN
  logic unused_dc;
  assign unused_dc = dc;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    calls           = up_q | dn_q | car_q;
    u_eff           = u_req;
    u_eff[NUM_FLOORS-1] = 1'b0;
    d_eff           = d_req;
    d_eff[0]        = 1'b0;
    fs_ok           = fs_valid && (int'(fs) < NUM_FLOORS);

    enter_open = 1'b0;
    open_up    = sweep_up;
    open_floor = cur;
    go_up      = 1'b0;
    go_dn      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_at(calls, cur)) begin
          enter_open = 1'b1;
          if (bit_at(up_q, cur))      open_up = 1'b1;
          else if (bit_at(dn_q, cur)) open_up = 1'b0;
        end else if (any_above(calls, cur)) begin
          go_up = 1'b1;
        end else if (any_below(calls, cur)) begin
          go_dn = 1'b1;
        end
      end
      UP: begin
        if (fs_ok && (bit_at(car_q | up_q, fs) || !any_above(calls, fs) ||
                      int'(fs) == NUM_FLOORS - 1)) begin
          enter_open = 1'b1;
          open_up    = 1'b1;
          open_floor = fs;
        end
      end
      DOWN: begin
        if (fs_ok && (bit_at(car_q | dn_q, fs) || !any_below(calls, fs) || int'(fs) == 0)) begin
          enter_open = 1'b1;
          open_up    = 1'b0;
          open_floor = fs;
        end
      end
      default: ;
    endcase
  end

  // Service masks: one-shot clear when the door opens, continuous clear at cur while open.
  always_comb begin
    ent_mask   = onehot(open_floor);
    ent_beyond = open_up ? any_above(calls, open_floor) : any_below(calls, open_floor);
    clr_car    = enter_open ? ent_mask : '0;
    clr_up     = (enter_open && (open_up || !ent_beyond)) ? ent_mask : '0;
    clr_dn     = (enter_open && (!open_up || !ent_beyond)) ? ent_mask : '0;

    more_ahead  = sweep_up ? any_above(calls, cur) : any_below(calls, cur);
    more_behind = sweep_up ? any_below(calls, cur) : any_above(calls, cur);
    cur_mask    = onehot(cur);
    srv_car     = (state == OPEN) ? cur_mask : '0;
    srv_up      = (state == OPEN && (sweep_up || !more_ahead)) ? cur_mask : '0;
    srv_dn      = (state == OPEN && (!sweep_up || !more_ahead)) ? cur_mask : '0;
    new_hit     = |((f_req & srv_car) | (u_eff & srv_up) | (d_eff & srv_dn));

    expire = (timer <= 8'd1);
`ifdef ELEVATOR_DOOR_CLOSE_EN
    if (dc && int'(timer) <= DOOR_CYCLES - 2) expire = 1'b1;
`endif

    // A fresh request beats the entry clear; the open-door clear beats everything.
    up_n  = ((up_q  & ~clr_up)  | u_eff) & ~srv_up;
    dn_n  = ((dn_q  & ~clr_dn)  | d_eff) & ~srv_dn;
    car_n = ((car_q & ~clr_car) | f_req) & ~srv_car;
  end

  // Reset release is retimed by one flop; state first evaluates on the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q    <= '0;
      dn_q    <= '0;
      car_q   <= '0;
      pending <= '0;
      cur     <= '0;
    end else if (run) begin
      up_q    <= up_n;
      dn_q    <= dn_n;
      car_q   <= car_n;
      pending <= up_n | dn_n | car_n;
      if (fs_ok) cur <= fs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      door     <= 1'b0;
      dir      <= DIR_STOP;
      timer    <= '0;
      sweep_up <= 1'b1;
    end else if (run) begin
      case (state)
        IDLE: begin
          if (enter_open) begin
            state    <= OPEN;
            door     <= 1'b1;
            timer    <= DOOR_LOAD;
            sweep_up <= open_up;
          end else if (go_up) begin
            state    <= UP;
            dir      <= DIR_UP;
            sweep_up <= 1'b1;
          end else if (go_dn) begin
            state    <= DOWN;
            dir      <= DIR_DN;
            sweep_up <= 1'b0;
          end
        end
        UP, DOWN: begin
          if (enter_open) begin
            state <= OPEN;
            door  <= 1'b1;
            dir   <= DIR_STOP;
            timer <= DOOR_LOAD;
          end
        end
        OPEN: begin
          if (new_hit) begin
            timer <= DOOR_LOAD;
          end else if (expire) begin
            door  <= 1'b0;
            timer <= '0;
            if (more_ahead) begin
              state <= sweep_up ? UP : DOWN;
              dir   <= sweep_up ? DIR_UP : DIR_DN;
            end else if (more_behind) begin
              state    <= sweep_up ? DOWN : UP;
              dir      <= sweep_up ? DIR_DN : DIR_UP;
              sweep_up <= !sweep_up;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_n.sv
// Directed bench for elevator_n: a 4-floor and a 16-floor instance, hand-computed expectations.
module tb_elevator_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  u_req, d_req, f_req;
  logic        dc;
  logic [1:0]  fs;
  logic        fs_valid;
  logic        door;
  logic [1:0]  dir;
  logic [3:0]  pending;

  logic [15:0] u16, d16, f16;
  logic [3:0]  fs16;
  logic        fsv16;
  logic        door16;
  logic [1:0]  dir16;
  logic [15:0] pending16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  elevator_n #(.NUM_FLOORS(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .u_req(u_req), .d_req(d_req), .f_req(f_req), .dc(dc),
    .fs(fs), .fs_valid(fs_valid), .door(door), .dir(dir), .pending(pending)
  );

  elevator_n #(.NUM_FLOORS(16), .DOOR_CYCLES(8)) dut16 (
    .clk(clk), .rst(rst), .u_req(u16), .d_req(d16), .f_req(f16), .dc(dc),
    .fs(fs16), .fs_valid(fsv16), .door(door16), .dir(dir16), .pending(pending16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] u, input logic [3:0] d, input logic [3:0] f);
    u_req = u; d_req = d; f_req = f;
    tick();
    u_req = '0; d_req = '0; f_req = '0;
  endtask

  task automatic arrive(input logic [1:0] f);
    fs = f; fs_valid = 1'b1;
    tick();
    fs_valid = 1'b0;
  endtask

  // Ticks until the door closes; n = -1 if it never does within the budget.
  task automatic wait_close(input bit big, output int n);
    n = 0;
    while (((big ? door16 : door) === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; u_req = '0; d_req = '0; f_req = '0; dc = 1'b0; fs = '0; fs_valid = 1'b0;
    u16 = '0; d16 = '0; f16 = '0; fs16 = '0; fsv16 = 1'b0;
    tick(); tick();
    n_total++; if (door !== 1'b0)  $display("FAIL reset_door: got %b want 0", door); else n_pass++;
    n_total++; if (dir !== 2'b00)  $display("FAIL reset_dir: got %b want 00", dir); else n_pass++;
    n_total++; if (pending !== 4'b0) $display("FAIL reset_pending: got %b want 0000", pending); else n_pass++;
    n_total++; if (pending16 !== 16'h0) $display("FAIL reset_pending16: got %h want 0000", pending16); else n_pass++;
    rst = 1'b1; f_req = 4'b0100;
    tick();
    n_total++; if (pending !== 4'b0000) $display("FAIL sync_edge1: pending %b want 0000", pending); else n_pass++;
    tick();
    f_req = '0;
    n_total++; if (pending !== 4'b0100) $display("FAIL sync_edge2: pending %b want 0100", pending); else n_pass++;
    tick();
    n_total++; if (dir !== 2'b01) $display("FAIL idle_to_up: dir %b want 01", dir); else n_pass++;
  endtask

  task automatic test_basic();
    int n;
    arrive(2'd2);
    n_total++; if (door !== 1'b1) $display("FAIL basic_open: door %b want 1", door); else n_pass++;
    n_total++; if (dir !== 2'b00) $display("FAIL basic_stop: dir %b want 00", dir); else n_pass++;
    n_total++; if (pending !== 4'b0000) $display("FAIL basic_clear: pending %b want 0000", pending); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (n !== 8) $display("FAIL basic_hold: door held %0d want 8", n); else n_pass++;
    n_total++; if (dir !== 2'b00) $display("FAIL basic_idle: dir %b want 00", dir); else n_pass++;
  endtask

  task automatic test_sweep();
    int n;
    pulse(4'b0000, 4'b0000, 4'b0001);
    tick();
    n_total++; if (dir !== 2'b10) $display("FAIL to_zero_dir: dir %b want 10", dir); else n_pass++;
    arrive(2'd0);
    wait_close(1'b0, n);
    n_total++; if (n !== 8) $display("FAIL to_zero_hold: %0d want 8", n); else n_pass++;
    pulse(4'b0010, 4'b0010, 4'b1000);
    n_total++; if (pending !== 4'b1010) $display("FAIL sweep_latch: pending %b want 1010", pending); else n_pass++;
    tick();
    n_total++; if (dir !== 2'b01) $display("FAIL sweep_up: dir %b want 01", dir); else n_pass++;
    arrive(2'd1);
    n_total++; if (door !== 1'b1) $display("FAIL stop1_door: door %b want 1", door); else n_pass++;
    n_total++; if (pending !== 4'b1010) $display("FAIL stop1_keep_down: pending %b want 1010", pending); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (dir !== 2'b01) $display("FAIL stop1_continue: dir %b want 01", dir); else n_pass++;
    arrive(2'd2);
    n_total++; if (door !== 1'b0 || dir !== 2'b01) $display("FAIL pass2: door %b dir %b want 0 01", door, dir); else n_pass++;
    arrive(2'd3);
    n_total++; if (pending !== 4'b0010) $display("FAIL stop3: pending %b want 0010", pending); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (dir !== 2'b10) $display("FAIL reverse: dir %b want 10", dir); else n_pass++;
    arrive(2'd2);
    n_total++; if (dir !== 2'b10) $display("FAIL pass2_down: dir %b want 10", dir); else n_pass++;
    arrive(2'd1);
    n_total++; if (door !== 1'b1 || pending !== 4'b0000) $display("FAIL stop1_down: door %b pending %b want 1 0000", door, pending); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (n !== 8 || dir !== 2'b00) $display("FAIL sweep_end: hold %0d dir %b want 8 00", n, dir); else n_pass++;
  endtask

  task automatic test_reload();
    int n;
    pulse(4'b0000, 4'b0000, 4'b0100);
    tick();
    arrive(2'd2);
    repeat (5) tick();
    f_req = 4'b0100;
    tick();
    f_req = '0;
    n_total++; if (door !== 1'b1 || pending !== 4'b0000) $display("FAIL reload_clear: door %b pending %b want 1 0000", door, pending); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (n !== 8) $display("FAIL reload_hold: %0d want 8", n); else n_pass++;
  endtask

  task automatic test_door_close();
    int n;
    pulse(4'b0000, 4'b0000, 4'b0100);
    n_total++; if (pending !== 4'b0100) $display("FAIL dc_latch: pending %b want 0100", pending); else n_pass++;
    tick();
    n_total++; if (door !== 1'b1) $display("FAIL dc_open: door %b want 1", door); else n_pass++;
    tick(); tick();
    dc = 1'b1;
    tick();
    dc = 1'b0;
`ifdef ELEVATOR_DOOR_CLOSE_EN
    n_total++; if (door !== 1'b0) $display("FAIL dc_close: door %b want 0", door); else n_pass++;
`else
    n_total++; if (door !== 1'b1) $display("FAIL dc_ignored: door %b want 1", door); else n_pass++;
    wait_close(1'b0, n);
    n_total++; if (n !== 5) $display("FAIL dc_full_hold: %0d want 5", n); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    pulse(4'b0000, 4'b0000, 4'b0001);
    n_total++; if (pending !== 4'b0001) $display("FAIL mid_latch: pending %b want 0001", pending); else n_pass++;
    tick();
    n_total++; if (dir !== 2'b10) $display("FAIL mid_down: dir %b want 10", dir); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (dir !== 2'b00 || door !== 1'b0 || pending !== 4'b0000) $display("FAIL mid_async: dir %b door %b pending %b want 00 0 0000", dir, door, pending); else n_pass++;
    tick();
    rst = 1'b1;
    tick(); tick();
    n_total++; if (pending !== 4'b0000 || dir !== 2'b00) $display("FAIL mid_discard: pending %b dir %b want 0000 00", pending, dir); else n_pass++;
    pulse(4'b0000, 4'b0000, 4'b0010);
    tick();
    n_total++; if (dir !== 2'b01) $display("FAIL mid_resume: dir %b want 01", dir); else n_pass++;
    arrive(2'd1);
    wait_close(1'b0, n);
    n_total++; if (n !== 8) $display("FAIL mid_hold: %0d want 8", n); else n_pass++;
  endtask

  task automatic test_n16();
    int n;
    f16 = 16'h8000;
    tick();
    f16 = '0;
    n_total++; if (pending16 !== 16'h8000) $display("FAIL n16_latch: pending %h want 8000", pending16); else n_pass++;
    tick();
    n_total++; if (dir16 !== 2'b01) $display("FAIL n16_up: dir %b want 01", dir16); else n_pass++;
    fs16 = 4'd15; fsv16 = 1'b1;
    tick();
    fsv16 = 1'b0;
    n_total++; if (door16 !== 1'b1 || pending16 !== 16'h0) $display("FAIL n16_top: door %b pending %h want 1 0000", door16, pending16); else n_pass++;
    wait_close(1'b1, n);
    n_total++; if (n !== 8) $display("FAIL n16_hold: %0d want 8", n); else n_pass++;
    u16 = 16'h8000;
    tick();
    u16 = '0;
    n_total++; if (pending16 !== 16'h0) $display("FAIL n16_top_up_ignored: pending %h want 0000", pending16); else n_pass++;
    tick();
    n_total++; if (door16 !== 1'b0 || dir16 !== 2'b00) $display("FAIL n16_stay_idle: door %b dir %b want 0 00", door16, dir16); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_reload();
    test_door_close();
    test_reset_mid();
    test_n16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/elevator_n.md
ELEVATOR_N -- requirements
Module: elevator_n

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 4, number of floors (legal 2..16); FW = $clog2(NUM_FLOORS).
REQ-002 SHALL have parameter DOOR_CYCLES, default 8, door-open hold time in clocks (legal 2..255).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 u_req  in  NUM_FLOORS  hall up-call pulses; bit NUM_FLOORS-1 ignored.
REQ-006 d_req  in  NUM_FLOORS  hall down-call pulses; bit 0 ignored.
REQ-007 f_req  in  NUM_FLOORS  in-car floor-button pulses.
REQ-008 dc  in  1  door-close button.
REQ-009 fs  in  FW  floor sensor, binary floor index; qualified by fs_valid.
REQ-010 fs_valid  in  1  car is level with floor fs this cycle.
REQ-011 door  out  1  1 = door open.
REQ-012 dir  out  2  motor command: 00 stop, 01 up, 10 down; 11 never driven.
REQ-013 pending  out  NUM_FLOORS  OR of all latched calls per floor, registered.

Function
REQ-014 Calls SHALL be latched into sticky up/down/car registers on the clock they are sampled high; repeats are harmless.
REQ-015 Current-floor register cur SHALL load fs on every cycle fs_valid=1 and fs<NUM_FLOORS; fs>=NUM_FLOORS SHALL be ignored.
REQ-016 FSM states: IDLE, UP, DOWN, OPEN; dir=01 only in UP, 10 only in DOWN, else 00; door=1 only in OPEN.
REQ-017 IDLE: any call at cur -> OPEN; else any call above cur -> UP; else any call below -> DOWN; else stay; priority in that order.
REQ-018 UP: on valid fs with f_req/u_req latched at fs, or no calls above fs, or fs=NUM_FLOORS-1 -> OPEN next cycle.
REQ-019 DOWN: on valid fs with f_req/d_req latched at fs, or no calls below fs, or fs=0 -> OPEN next cycle.
REQ-020 Entering OPEN SHALL clear car call at cur plus hall call in sweep direction; opposite hall call also cleared when no calls remain beyond cur in sweep direction.
REQ-021 OPEN loads timer with DOOR_CYCLES; door stays 1 exactly DOOR_CYCLES clocks absent other events.
REQ-022 New call at cur arriving in OPEN SHALL be cleared the same cycle and reload the timer.
REQ-023 Timer expiry: calls beyond cur in sweep direction -> continue; else calls opposite -> reverse; else IDLE; from IDLE entry, sweep = direction of the call served.
REQ-024 Call set and service-clear for the same floor in the same cycle: clear wins only in OPEN at that floor; otherwise set wins.
REQ-025 Timer width 8 bits; no wrap; saturates at 0.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, door=0, dir=00, pending=0, all call registers 0, cur=0, timer=0, sweep=up.
REQ-027 Deassertion SHALL be synchronised to clk; first state evaluation on the second rising edge after release.
REQ-028 Reset mid-travel or mid-OPEN SHALL discard all calls; no call survives reset.

Configuration
REQ-029 Macro ELEVATOR_DOOR_CLOSE_EN: when defined, dc=1 in OPEN after at least 2 door-open clocks SHALL force timer expiry next cycle; REQ-022 reload overrides dc.
REQ-030 Without ELEVATOR_DOOR_CLOSE_EN, dc SHALL be ignored; port remains.

Verification
REQ-031 Reset, then f_req[2] pulse, cur=0, N=4 -> dir=01; fs_valid fs=2 -> door=1 next cycle, held 8 clocks, then IDLE, pending=0.
REQ-032 Moving up from 0 with u_req[1], d_req[1], f_req[3]: stop at 1 clears only u_req[1]; continue to 3; reverse; stop at 1 clears d_req[1].
REQ-033 Door open at floor 2, f_req[2] pulse at timer=3 -> timer reloads, door stays 1 for 8 further clocks.
REQ-034 ELEVATOR_DOOR_CLOSE_EN defined: dc=1 on 3rd open clock -> door=0 next cycle; undefined: door open full 8 clocks.
REQ-035 rst=0 asserted while dir=10 -> dir=00, door=0, pending=0 without clock edge; later calls served normally.
REQ-036 NUM_FLOORS=16: f_req[15] from floor 0; fs=15 -> OPEN; fs=15 with u_req[15] only -> ignored, pending=0.
